// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// mem_access_ctrl
//   Memory-side responder for the address selected by the IorD mux. Accepts one
//   load/store per req handshake and drives a 1-cycle-latency synchronous word
//   RAM. Loads extract and sign/zero-extend byte or halfword lanes. Sub-word
//   stores are done as read-modify-write. Misaligned or out-of-range accesses
//   complete with an error flag and no RAM cycle.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   req_i        request, sampled only in idle
//   we_i         1 = store, 0 = load
//   size_i       00 word, 01 half, 10 byte, 11 reserved
//   sign_ext_i   loads: 1 = sign-extend, 0 = zero-extend
//   addr_i       byte address
//   wdata_i      store data, right-aligned for sub-word sizes
//   ack_o        one-cycle completion pulse
//   rdata_o      load result, valid with ack, held until the next load ack
//   busy_o       access in progress (state != idle)
//   misalign_o   pulse with ack: misaligned address or reserved size
//   oob_o        pulse with ack: word index beyond RAM depth
//   mem_addr_o   RAM word address
//   mem_we_o     RAM write enable
//   mem_wdata_o  RAM write data
//   mem_rdata_i  RAM read data, valid one cycle after mem_addr_o

module mem_access_ctrl #(
  parameter int unsigned MemWords = 256,
  parameter int unsigned MemAw    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic             sign_ext_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic             ack_o,
  output logic [31:0]      rdata_o,
  output logic             busy_o,
  output logic             misalign_o,
  output logic             oob_o,
  output logic [MemAw-1:0] mem_addr_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam logic [1:0] SizeWord = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StRd,
    StRdCap,
    StWr,
    StRmwRd,
    StRmwMrg,
    StRmwWr,
    StAck,
    StErrAck
  } state_e;

  state_e state_q, state_d;

  // Access attributes latched at acceptance.
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [1:0]       lane_q, lane_d;
  logic [15:0]      wlow_q, wlow_d;

  // Registered outputs.
  logic             ack_q, ack_d;
  logic             misalign_q, misalign_d;
  logic             oob_q, oob_d;
  logic             busy_q, busy_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [MemAw-1:0] mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  // Acceptance-time error decode.
  logic req_misalign;
  logic req_oob;

  always_comb begin
    req_misalign = (size_i == SizeRsvd) ||
                   ((size_i == SizeHalf) && addr_i[0]) ||
                   ((size_i == SizeWord) && (addr_i[1:0] != 2'b00));
    req_oob      = (addr_i[31:2] >= 30'(MemWords));
  end

  // Lane extraction for loads and lane replacement for sub-word stores, both
  // working on the RAM word that arrives one cycle after the address.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] merged;

  always_comb begin
    ld_byte = mem_rdata_i[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      SizeByte: ld_value = {{24{sext_q & ld_byte[7]}}, ld_byte};
      SizeHalf: ld_value = {{16{sext_q & ld_half[15]}}, ld_half};
      default:  ld_value = mem_rdata_i;
    endcase

    merged = mem_rdata_i;
    if (size_q == SizeByte) begin
      merged[{lane_q, 3'b000} +: 8] = wlow_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wlow_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    wlow_d      = wlow_q;
    ack_d       = 1'b0;
    misalign_d  = 1'b0;
    oob_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          size_d = size_i;
          sext_d = sign_ext_i;
          lane_d = addr_i[1:0];
          wlow_d = wdata_i[15:0];
          if (req_misalign || req_oob) begin
            state_d    = StErrAck;
            ack_d      = 1'b1;
            misalign_d = req_misalign;
            oob_d      = req_oob;
          end else begin
            mem_addr_d = addr_i[MemAw+1:2];
            if (!we_i) begin
              state_d = StRd;
            end else if (size_i == SizeWord) begin
              state_d     = StWr;
              mem_we_d    = 1'b1;
              mem_wdata_d = wdata_i;
            end else begin
              state_d = StRmwRd;
            end
          end
        end
      end
      StRd: begin
        state_d = StRdCap;
      end
      StRdCap: begin
        rdata_d = ld_value;
        state_d = StAck;
        ack_d   = 1'b1;
      end
      StWr: begin
        state_d = StAck;
        ack_d   = 1'b1;
      end
      StRmwRd: begin
        state_d = StRmwMrg;
      end
      StRmwMrg: begin
        mem_wdata_d = merged;
        mem_we_d    = 1'b1;
        state_d     = StRmwWr;
      end
      StRmwWr: begin
        state_d = StAck;
        ack_d   = 1'b1;
      end
      StAck, StErrAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // Asynchronous reset clears mem_we_q at once, so an abort in StRmwWr never
  // reaches the RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      lane_q      <= 2'b00;
      wlow_q      <= 16'h0000;
      ack_q       <= 1'b0;
      misalign_q  <= 1'b0;
      oob_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      wlow_q      <= wlow_d;
      ack_q       <= ack_d;
      misalign_q  <= misalign_d;
      oob_q       <= oob_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack_o       = ack_q;
  assign misalign_o  = misalign_q;
  assign oob_o       = oob_q;
  assign busy_o      = busy_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int unsigned MemWords = 256;
  localparam int unsigned MemAw    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic             we = 1'b0;
  logic [1:0]       size = 2'b00;
  logic             sext = 1'b0;
  logic [31:0]      addr = 32'h0;
  logic [31:0]      wdata = 32'h0;
  logic             ack;
  logic [31:0]      rdata;
  logic             busy;
  logic             misalign;
  logic             oob;
  logic [MemAw-1:0] mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  logic [31:0] ram [MemWords];

  int checks = 0;
  int failures = 0;
  int lat;

  mem_access_ctrl #(
    .MemWords(MemWords),
    .MemAw   (MemAw)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .sign_ext_i (sext),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .ack_o      (ack),
    .rdata_o    (rdata),
    .busy_o     (busy),
    .misalign_o (misalign),
    .oob_o      (oob),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one accepting edge, then scrambles the inputs so
  // that only latched values can produce correct results. Returns at T+1.
  task automatic issue(input logic w, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d);
    we = w; size = s; sext = se; addr = a; wdata = d; req = 1'b1;
    step();
    req = 1'b0; we = ~w; size = 2'b11; sext = ~se; addr = 32'h0000_0003;
    wdata = 32'hA5A5_A5A5;
  endtask

  task automatic wait_ack(input int start, output int l);
    l = start;
    while (ack !== 1'b1 && l < 12) begin
      step();
      l++;
    end
  endtask

  task automatic do_load(input string tag, input logic [1:0] s, input logic se,
                         input logic [31:0] a, input logic [31:0] exp);
    int l;
    issue(1'b0, s, se, a, 32'h0);
    wait_ack(1, l);
    chk({tag, "_lat"}, 32'(l), 32'd3);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_flags"}, {30'b0, misalign, oob}, 32'h0);
    step();
    chk({tag, "_idle"}, {30'b0, ack, busy}, 32'h0);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_memwe", {31'b0, mem_we}, 32'h0);
    chk("rst_memaddr", 32'(mem_addr), 32'h0);
    chk("rst_flags", {30'b0, misalign, oob}, 32'h0);
    rst_n = 1'b1;
    step();
    step();

    // Word store: write at T+1, ack at T+2.
    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("sw_memwe", {31'b0, mem_we}, 32'h1);
    chk("sw_memaddr", 32'(mem_addr), 32'h4);
    chk("sw_memwdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_busy", {31'b0, busy}, 32'h1);
    wait_ack(1, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_ram", ram[4], 32'hDEAD_BEEF);
    step();
    chk("sw_idle", {30'b0, ack, busy}, 32'h0);

    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h8899_AABB);
    wait_ack(1, lat);
    chk("sw2_lat", 32'(lat), 32'd2);
    step();
    chk("sw2_ram", ram[4], 32'h8899_AABB);

    // Loads with lane extraction and extension.
    do_load("lb_s", 2'b10, 1'b1, 32'h12, 32'hFFFF_FF99);
    do_load("lb_z", 2'b10, 1'b0, 32'h12, 32'h0000_0099);
    do_load("lb_s0", 2'b10, 1'b1, 32'h10, 32'hFFFF_FFBB);
    do_load("lh_s", 2'b01, 1'b1, 32'h12, 32'hFFFF_8899);
    do_load("lh_z", 2'b01, 1'b0, 32'h10, 32'h0000_AABB);
    do_load("lw", 2'b00, 1'b1, 32'h10, 32'h8899_AABB);

    // Halfword RMW: write of merged word at T+3, ack at T+4.
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234);
    chk("sh_t1_we", {31'b0, mem_we}, 32'h0);
    step();
    chk("sh_t2_we", {31'b0, mem_we}, 32'h0);
    step();
    chk("sh_t3_we", {31'b0, mem_we}, 32'h1);
    chk("sh_t3_wdata", mem_wdata, 32'h1234_AABB);
    chk("sh_t3_addr", 32'(mem_addr), 32'h4);
    wait_ack(3, lat);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_ram", ram[4], 32'h1234_AABB);
    step();

    // Byte RMW in lane 1.
    issue(1'b1, 2'b10, 1'b0, 32'h11, 32'hCCCC_CC55);
    wait_ack(1, lat);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_ram", ram[4], 32'h1234_55BB);
    chk("sb_rdata_held", rdata, 32'h8899_AABB);
    step();

    // Error completions at T+1 with no RAM cycle.
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("mis_ack", {31'b0, ack}, 32'h1);
    chk("mis_flags", {30'b0, misalign, oob}, 32'h2);
    chk("mis_memwe", {31'b0, mem_we}, 32'h0);
    chk("mis_rdata", rdata, 32'h8899_AABB);
    step();
    chk("mis_idle", {30'b0, ack, busy}, 32'h0);

    issue(1'b0, 2'b00, 1'b0, 32'(4 * MemWords), 32'h0);
    chk("oob_ack", {31'b0, ack}, 32'h1);
    chk("oob_flags", {30'b0, misalign, oob}, 32'h1);
    step();

    issue(1'b1, 2'b11, 1'b0, 32'(4 * MemWords + 1), 32'h0);
    chk("both_ack", {31'b0, ack}, 32'h1);
    chk("both_flags", {30'b0, misalign, oob}, 32'h3);
    chk("both_memwe", {31'b0, mem_we}, 32'h0);
    step();
    chk("both_ram", ram[4], 32'h1234_55BB);

    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h0);
    chk("sh_odd_flags", {30'b0, misalign, oob}, 32'h2);
    step();

    // Back-to-back halfword loads with req held high.
    we = 1'b0; size = 2'b01; sext = 1'b0; addr = 32'h10; req = 1'b1;
    step();
    chk("b2b_busy1", {31'b0, busy}, 32'h1);
    addr = 32'h12; sext = 1'b1;
    wait_ack(1, lat);
    chk("b2b_lat1", 32'(lat), 32'd3);
    chk("b2b_rdata1", rdata, 32'h0000_55BB);
    chk("b2b_busy_ack1", {31'b0, busy}, 32'h1);
    step();
    chk("b2b_idle", {30'b0, ack, busy}, 32'h0);
    step();
    chk("b2b_busy2", {31'b0, busy}, 32'h1);
    req = 1'b0;
    wait_ack(1, lat);
    chk("b2b_lat2", 32'(lat), 32'd3);
    chk("b2b_rdata2", rdata, 32'h0000_1234);
    step();
    chk("b2b_end1", {30'b0, ack, busy}, 32'h0);
    step();
    chk("b2b_end2", {30'b0, ack, busy}, 32'h0);

    // Reset in RMW write cycle aborts the write.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h77);
    step();
    step();
    chk("abort_pre_we", {31'b0, mem_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we", {31'b0, mem_we}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_noack", {31'b0, ack}, 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_noack2", {31'b0, ack}, 32'h0);
    end
    chk("abort_ram", ram[4], 32'h1234_55BB);
    chk("abort_rdata", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
